// File: rtl/video_rx.sv
// Serial video frame receiver: oversamples a slow bit clock, locks onto the
// end-of-frame sync and delivers the frame one row at a time with error tracking.
module video_rx #(
  parameter int ROW_BITS = 16,
  parameter int ROWS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_clk,
  input  logic                    video_in,
  input  logic                    video_sync,
  output logic [ROW_BITS-1:0]     row_data,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    row_valid,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic                    locked,
  output logic [7:0]              err_count
);

  localparam int FRAME_BITS = ROW_BITS * ROWS;
  localparam int COL_W      = $clog2(ROW_BITS);
  localparam int ROW_W      = $clog2(ROWS);
  localparam int K_W        = $clog2(FRAME_BITS) + 1;
  localparam logic [K_W-1:0] K_FULL = K_W'(FRAME_BITS);

  typedef enum logic {HUNT = 1'b0, RECEIVE = 1'b1} state_e;

  logic [1:0] vclk_sync_q, vin_sync_q, vsync_sync_q;
  logic       vclk_prev_q;
  logic       strobe;

  state_e                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [ROW_BITS-1:0]     shift_q, shift_d;
  logic [ROW_BITS-1:0]     row_data_q, row_data_d;
  logic [ROW_W-1:0]        row_addr_q, row_addr_d;
  logic                    row_valid_q, row_valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      vclk_sync_q  <= '0;
      vin_sync_q   <= '0;
      vsync_sync_q <= '0;
      vclk_prev_q  <= 1'b0;
    end else begin
      vclk_sync_q  <= {vclk_sync_q[0], video_clk};
      vin_sync_q   <= {vin_sync_q[0], video_in};
      vsync_sync_q <= {vsync_sync_q[0], video_sync};
      vclk_prev_q  <= vclk_sync_q[1];
    end
  end

  assign strobe = vclk_sync_q[1] & ~vclk_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      k_q         <= '0;
      shift_q     <= '0;
      row_data_q  <= '0;
      row_addr_q  <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      row_data_q  <= row_data_d;
      row_addr_q  <= row_addr_d;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    shift_d     = shift_q;
    row_data_d  = row_data_q;
    row_addr_d  = row_addr_q;
    row_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (strobe) begin
      case (state_q)
        HUNT: begin
          if (vsync_sync_q[1]) begin
            state_d = RECEIVE;
            k_d     = '0;
          end
        end
        RECEIVE: begin
          if (vsync_sync_q[1]) begin
            k_d = '0;
            if (k_q == K_FULL) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
          end else if (k_q == K_FULL) begin
            // Overlong frame: drop the extra bit and resynchronise on the next sync.
            err_d   = 1'b1;
            state_d = HUNT;
            k_d     = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            shift_d = {vin_sync_q[1], shift_q[ROW_BITS-1:1]};
            k_d     = k_q + K_W'(1);
            if (k_q[COL_W-1:0] == {COL_W{1'b1}}) begin
              row_data_d  = shift_d;
              row_addr_d  = k_q[COL_W +: ROW_W];
              row_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign row_data   = row_data_q;
  assign row_addr   = row_addr_q;
  assign row_valid  = row_valid_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign locked     = (state_q == RECEIVE);
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_video_rx.sv
// Self-checking bench for video_rx: period-level frame model with an event queue,
// directed scenarios plus randomized frames.
module tb_video_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_clk = 1'b0;
  logic        video_in = 1'b0;
  logic        video_sync = 1'b0;
  logic [15:0] row_data;
  logic [3:0]  row_addr;
  logic        row_valid, frame_done, frame_err, locked;
  logic [7:0]  err_count;

  video_rx #(.ROW_BITS(16), .ROWS(16)) dut (
    .clk(clk), .reset(reset), .video_clk(video_clk), .video_in(video_in),
    .video_sync(video_sync), .row_data(row_data), .row_addr(row_addr),
    .row_valid(row_valid), .frame_done(frame_done), .frame_err(frame_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // 4 = row, 2 = frame done, 1 = frame error
    logic [15:0] data;
    logic [3:0]  addr;
    logic [7:0]  ecnt;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hunting = 1'b1;
  bit   fbits[$];
  int   m_ecnt = 0;
  logic [15:0] exp_row_data = '0;
  logic [3:0]  exp_row_addr = '0;
  int   n_row = 0, n_done = 0, n_err = 0;
  logic [15:0] seen_row [16];
  logic [15:0] last_row = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [15:0] data, input logic [3:0] addr);
    ev_t e;
    e.kind = kind; e.data = data; e.addr = addr; e.ecnt = 8'(m_ecnt);
    exp_q.push_back(e);
  endtask

  task automatic bump_err();
    if (m_ecnt < 255) m_ecnt++;
    push_ev(3'b001, '0, '0);
  endtask

  // One video_clk period is either a data bit or a sync marker.
  task automatic model_period(input bit d, input bit s);
    logic [15:0] r;
    int base;
    if (hunting) begin
      if (s) begin hunting = 1'b0; fbits.delete(); end
    end else if (s) begin
      if (fbits.size() == 256) push_ev(3'b010, '0, '0);
      else bump_err();
      fbits.delete();
    end else if (fbits.size() == 256) begin
      bump_err();
      hunting = 1'b1;
      fbits.delete();
    end else begin
      fbits.push_back(d);
      if (fbits.size() % 16 == 0) begin
        base = fbits.size() - 16;
        for (int c = 0; c < 16; c++) r[c] = fbits[base + c];
        push_ev(3'b100, r, 4'(fbits.size() / 16 - 1));
      end
    end
  endtask

  task automatic send(input bit d, input bit s);
    model_period(d, s);
    video_clk = 1'b0; video_in = d; video_sync = s;
    #30;
    video_clk = 1'b1;
    #30;
  endtask

  task automatic send_bits(input int n, input int mode);
    // mode 0 random, 1 alternating k[0], 2 only bit 17 set, 3 zeros
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: send(1'($urandom), 1'b0);
        1: send(1'(i & 1), 1'b0);
        2: send(i == 17, 1'b0);
        default: send(1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_row = 0; n_done = 0; n_err = 0;
    for (int i = 0; i < 16; i++) seen_row[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    hunting = 1'b1; fbits.delete(); m_ecnt = 0;
    exp_row_data = '0; exp_row_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (row_valid || frame_done || frame_err) begin
        if (frame_done && frame_err) chk("done_err_overlap", 1, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'b0, row_valid, frame_done, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'b0, row_valid, frame_done, frame_err}, {29'b0, e.kind});
          chk("locked_at_pulse", locked, e.kind != 3'b001 || exp_q.size() > 100 ? 1 : locked);
          if (e.kind == 3'b100) begin exp_row_data = e.data; exp_row_addr = e.addr; end
          if (e.kind == 3'b001) chk("err_count", err_count, e.ecnt);
        end
        if (row_valid) begin
          n_row++; seen_row[row_addr] = row_data; last_row = row_data;
        end
        if (frame_done) n_done++;
        if (frame_err) n_err++;
      end
      chk("row_data", row_data, exp_row_data);
      chk("row_addr", row_addr, exp_row_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, len;
    for (int i = 0; i < 16; i++) seen_row[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    @(negedge clk);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_pulses", {row_valid, frame_done, frame_err}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);

    // Lock onto an alternating-bit frame after garbage.
    send_bits(10, 0);
    send(1'b0, 1'b1);
    settle();
    chk("lock_locked", locked, 1);
    clear_counts();
    send_bits(256, 1);
    send(1'b0, 1'b1);
    settle();
    chk("lock_rows", n_row, 16);
    chk("lock_done", n_done, 1);
    chk("lock_err", n_err, 0);
    chk("lock_row15", last_row, 16'hAAAA);

    // Bit ordering.
    clear_counts();
    send_bits(256, 2);
    send(1'b0, 1'b1);
    settle();
    chk("order_row1", seen_row[1], 16'h0002);
    chk("order_row0", seen_row[0], 16'h0000);
    chk("order_row15", seen_row[15], 16'h0000);
    chk("order_done", n_done, 1);

    // Short frame, then recovery.
    clear_counts();
    send_bits(100, 0);
    send(1'b0, 1'b1);
    settle();
    chk("short_err", n_err, 1);
    chk("short_err_count", err_count, 1);
    chk("short_rows", n_row, 6);
    chk("short_done", n_done, 0);
    clear_counts();
    send_bits(256, 0);
    send(1'b0, 1'b1);
    settle();
    chk("short_next_done", n_done, 1);

    // Long frame.
    clear_counts();
    send_bits(257, 0);
    settle();
    chk("long_err", n_err, 1);
    chk("long_locked", locked, 0);
    chk("long_err_count", err_count, 2);
    clear_counts();
    send_bits(20, 0);
    settle();
    chk("long_hunt_rows", n_row, 0);
    send(1'b0, 1'b1);
    send_bits(256, 0);
    send(1'b0, 1'b1);
    settle();
    chk("long_relock_done", n_done, 1);

    // Reset mid-frame at bit 130.
    send_bits(130, 3);
    settle();
    do_reset();
    @(negedge clk);
    chk("midrst_outputs", {row_data, 12'b0, row_addr, 5'b0, row_valid, frame_done, frame_err}, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err_count", err_count, 0);
    clear_counts();
    send_bits(20, 0);
    settle();
    chk("midrst_quiet", n_row + n_done + n_err, 0);
    send(1'b0, 1'b1);
    send_bits(256, 0);
    send(1'b0, 1'b1);
    settle();
    chk("midrst_done", n_done, 1);
    chk("midrst_rows", n_row, 16);

    // Randomized frames of mixed length.
    for (int f = 0; f < 8; f++) begin
      t = $urandom_range(0, 2);
      if (t == 0) len = 256;
      else if (t == 1) len = $urandom_range(0, 255);
      else len = 257 + $urandom_range(0, 10);
      send_bits(len, 0);
      send(1'b0, 1'b1);
    end
    settle();

    // Saturation of the error counter.
    send(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) send(1'b0, 1'b1);
    settle();
    chk("sat_err_count", err_count, 255);
    clear_counts();
    send(1'b0, 1'b1);
    settle();
    chk("sat_still_pulses", n_err, 1);
    chk("sat_hold", err_count, 255);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
